// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: MEM-stage peripheral access controller.
//
// Detects loads/stores whose effective address falls inside the peripheral
// window and runs each one as a single APB4 transfer. The pipeline is stalled
// until the transfer completes. The result is then presented for one cycle so
// the MEM/WB register can capture it.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that waits
// too long on PREADY.
//
// Ports:
//   clk, rst                 system clock, synchronous active-low reset
//   MemReadM, MemWriteM      MEM-stage load / store
//   MemStrobeM               access size: 00 byte, 01 half, 10 word, 11 reserved
//   ALUResultM, WriteDataM   effective address, right-aligned store data
//   PREADY, PRDATA, PSLVERR  APB completer response
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA, PSTRB     APB requester outputs
//   StallPeriph              freezes F/D/E/M stages and the M/W register
//   periph_rdata             raw captured PRDATA word
//   periph_rvalid            load-complete pulse
//   store_done               store-complete pulse
//   periph_err               error pulse (misaligned, PSLVERR or timeout)
module apb_mem_ctrl #(
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemStrobeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        PREADY,
    input  logic [31:0] PRDATA,
    input  logic        PSLVERR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    output logic        StallPeriph,
    output logic [31:0] periph_rdata,
    output logic        periph_rvalid,
    output logic        store_done,
    output logic        periph_err
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [29:0] addr_q;
    logic        write_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        hit;
    logic        misaligned;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic        timeout_hit;

    assign hit = (MemReadM | MemWriteM) & ((ALUResultM & PERIPH_MASK) == PERIPH_BASE);

    always_comb begin
        unique case (MemStrobeM)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ALUResultM[0];
            2'b10:   misaligned = |ALUResultM[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane formatting is resolved at latch time so the APB outputs come
    // straight from flops and stay constant for the whole transfer.
    always_comb begin
        strb_d  = 4'b0000;
        wdata_d = WriteDataM;
        unique case (MemStrobeM)
            2'b00: begin
                strb_d  = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: begin
                strb_d  = 4'b1111;
                wdata_d = WriteDataM;
            end
        endcase
        if (!MemWriteM) begin
            strb_d = 4'b0000;
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    assign timeout_hit = (state_q == StAccess) & ~PREADY & (cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else if (state_q == StSetup) begin
            cnt_q <= 8'd0;
        end else if (state_q == StAccess && !PREADY) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    state_d = misaligned ? StDone : StSetup;
                end
            end
            StSetup:  state_d = StAccess;
            StAccess: begin
                if (PREADY || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && hit) begin
                // Direction is kept even for misaligned hits so the completion
                // pulse still reports load vs store.
                write_q <= MemWriteM;
                err_q   <= misaligned;
                if (!misaligned) begin
                    addr_q  <= ALUResultM[31:2];
                    strb_q  <= strb_d;
                    wdata_q <= wdata_d;
                end
            end
            if (state_q == StAccess) begin
                if (PREADY) begin
                    rdata_q <= PRDATA;
                    err_q   <= PSLVERR;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign PSEL          = (state_q == StSetup) | (state_q == StAccess);
    assign PENABLE       = (state_q == StAccess);
    assign PWRITE        = write_q;
    assign PADDR         = {addr_q, 2'b00};
    assign PSTRB         = strb_q;
    assign PWDATA        = wdata_q;
    assign StallPeriph   = ((state_q == StIdle) & hit) | PSEL;
    assign periph_rdata  = rdata_q;
    assign periph_rvalid = (state_q == StDone) & ~write_q;
    assign store_done    = (state_q == StDone) & write_q;
    assign periph_err    = (state_q == StDone) & err_q;

endmodule

// File: doc/apb_mem_ctrl.md
# apb_mem_ctrl

Memory-stage peripheral access controller for the pipelined RV32I core. It detects MEM-stage loads and stores whose address falls in the peripheral window and runs each one as a single APB4 transfer. The pipeline is stalled until the transfer completes, then the read data, store-completion flag and error flag are presented for the MEM/WB register to capture. It sits between the MEM stage and the APB bridge, and is the sole source of the pipeline-wide peripheral stall.

## Interface

Parameters:
- PERIPH_BASE, 32'h4000_0000, base address of the peripheral window.
- PERIPH_MASK, 32'hF000_0000, address bits compared against PERIPH_BASE.
- TIMEOUT, 64, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, synchronous, active-low reset.
- MemReadM, input, 1, MEM-stage instruction is a load.
- MemWriteM, input, 1, MEM-stage instruction is a store.
- MemStrobeM, input, 2, access size: 00 byte, 01 half, 10 word, 11 reserved.
- ALUResultM, input, 32, effective address.
- WriteDataM, input, 32, store data, right-aligned.
- PREADY, input, 1, APB ready.
- PRDATA, input, 32, APB read data.
- PSLVERR, input, 1, APB slave error.
- PSEL, output, 1, APB select.
- PENABLE, output, 1, APB enable.
- PWRITE, output, 1, APB direction.
- PADDR, output, 32, word-aligned address.
- PWDATA, output, 32, lane-replicated write data.
- PSTRB, output, 4, APB byte strobes.
- StallPeriph, output, 1, freezes the F, D, E and M stages and the M/W register.
- periph_rdata, output, 32, raw PRDATA word; valid in DONE.
- periph_rvalid, output, 1, one-cycle pulse in DONE for loads.
- store_done, output, 1, one-cycle pulse in DONE for stores.
- periph_err, output, 1, one-cycle pulse in DONE on error.

## Operation

- hit = (MemReadM | MemWriteM) & ((ALUResultM & PERIPH_MASK) == PERIPH_BASE).
- Misaligned accesses are errors: half with addr[0]=1, word with addr[1:0]≠0, or MemStrobeM=11.
- States are IDLE, SETUP, ACCESS and DONE.
- IDLE:
  - hit & aligned: latch address, data, size and direction, then go to SETUP.
  - hit & misaligned: go to DONE with the error flag set and no APB transfer.
  - otherwise: stay in IDLE.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. Stay while PREADY=0. On PREADY=1, capture PRDATA and PSLVERR, then go to DONE.
- DONE: PSEL=0. Pulse the outputs, then go to IDLE. A hit seen in DONE is ignored because it belongs to the departing instruction.
- StallPeriph = (IDLE & hit) | SETUP | ACCESS. It is combinational and is 0 in DONE.
- All APB outputs are driven from latched values and held constant through SETUP and ACCESS.
- PADDR = {addr[31:2], 2'b00}. PWRITE = latched store flag.
- PSTRB for stores:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- PSTRB is 0 for reads.
- PWDATA for stores:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- periph_rdata is the raw 32-bit word; lane extraction is done downstream.

## Timing

- Reset value of every output is 0, and the state is IDLE.
- Reset applied mid-transfer abandons the APB transfer at that edge.
- Zero-wait access: hit in cycle 0 (IDLE), SETUP in cycle 1, ACCESS in cycle 2, DONE in cycle 3.
- The instruction leaves M at the end of cycle 3, so it spends 4 cycles in M.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Back-to-back peripheral accesses: the next hit is detected in the cycle after DONE, giving a minimum of 4 cycles per access.
- A misaligned hit goes IDLE to DONE and spends 2 cycles in M.
- periph_rdata holds its value until the next capture.

## Configuration

- APB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each PREADY=0 cycle.
  - When the count reaches TIMEOUT-1 with PREADY still 0, the transfer aborts: PSEL and PENABLE drop, state goes to DONE, periph_err=1, periph_rdata=0.
- APB_TIMEOUT_EN undefined: ACCESS waits indefinitely and no counter is synthesized.

## Test plan

- Word load at 0x4000_0010, PREADY=1, PRDATA=0xCAFE_F00D:
  - StallPeriph=1 for cycles 0–2.
  - PSEL/PENABLE show SETUP then ACCESS.
  - periph_rvalid=1 and periph_rdata=0xCAFE_F00D in cycle 3.
- Byte store 0xA5 at 0x4000_0003 with 3 PREADY=0 cycles:
  - PSTRB=4'b1000, PWDATA=0xA5A5_A5A5, PWRITE=1.
  - APB outputs are stable during the waits.
  - store_done pulses in cycle 6.
- Half store at 0x4000_0001:
  - No PSEL.
  - periph_err pulses in cycle 1.
  - StallPeriph=1 for cycle 0 only.
- Load at 0x2000_0000 (outside the window): StallPeriph=0 and PSEL never asserts.
- rst=0 during ACCESS: at the next edge all outputs are 0 and the state is IDLE; with hit=0 it stays idle.
- With APB_TIMEOUT_EN, TIMEOUT=4 and PREADY held at 0:
  - Abort after the 4th ACCESS cycle.
  - periph_err=1 and periph_rdata=0.
